lf_multiprecision_sequencer: RTL and testbench

Multi-cycle sequencer that performs TOTAL-bit add/subtract by time-multiplexing one WIDTH-bit Ladner_fischer_adder instance over SLICES operand slices, least-significant first. A registered carry chains the slices. Operands are accepted and results delivered over valid/ready handshakes. It sits between a wide-operand producer (e.g. an accumulator or multi-precision unit) and the shared prefix adder, and owns that adder's sequencing.

---
 rtl/lf_multiprecision_sequencer_pkg.sv | 51 +++++
 rtl/lf_multiprecision_sequencer_adder.sv | 58 +++++
 rtl/lf_multiprecision_sequencer.sv | 147 ++++++++++++++
 tb/tb_lf_multiprecision_sequencer.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lf_multiprecision_sequencer_pkg.sv
// Shared types and elaboration helpers for the multi-precision sequencer
// and its Ladner-Fischer slice adder.
package lf_multiprecision_sequencer_pkg;

  // Sequencer states: accept, slice-by-slice add, hold result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seqState_e;

  // Ceiling log2, never below 1 so a single-slice build still has a counter bit.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem = rem >> 1;
    end
    if (result < 1) begin
      result = 1;
    end
    return result;
  endfunction

  // Integer power, used to size the span of each prefix level.
  function automatic int intPow(input int base, input int exponent);
    int result;
    result = 1;
    for (int e = 0; e < exponent; e++) begin
      result = result * base;
    end
    return result;
  endfunction

  // Number of prefix levels needed so that valency^levels covers the width.
  function automatic int prefixLevels(input int width, input int valency);
    int levels;
    int span;
    levels = 0;
    span = 1;
    while (span < width) begin
      span = span * valency;
      levels = levels + 1;
    end
    return levels;
  endfunction

endpackage

// File: rtl/lf_multiprecision_sequencer_adder.sv
// Ladner-Fischer (divide-and-conquer) parallel prefix adder with a
// configurable valency. At level lv every bit whose base-VALENCY digit
// at position lv is nonzero merges in the lower sibling groups, so after
// all levels each bit holds the group generate/propagate from bit 0.
module Ladner_fischer_adder
  import lf_multiprecision_sequencer_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int VALENCY = 2
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o
);

  localparam int LEVELS = prefixLevels(WIDTH, VALENCY);

  logic [LEVELS:0][WIDTH-1:0] gLvl;
  logic [LEVELS:0][WIDTH-1:0] pLvl;
  logic [WIDTH:0]             carry;

  assign gLvl[0] = a_i & b_i;
  assign pLvl[0] = a_i ^ b_i;

  for (genvar lv = 0; lv < LEVELS; lv++) begin : gLevel
    localparam int SPAN = intPow(VALENCY, lv);
    for (genvar i = 0; i < WIDTH; i++) begin : gBit
      localparam int DIGIT = (i / SPAN) % VALENCY;
      logic [VALENCY-1:0] gChain;
      logic [VALENCY-1:0] pChain;
      assign gChain[0] = gLvl[lv][i];
      assign pChain[0] = pLvl[lv][i];
      for (genvar m = 1; m < VALENCY; m++) begin : gCell
        if (m <= DIGIT) begin : gMerge
          localparam int SRC = ((i / SPAN) - m + 1) * SPAN - 1;
          assign gChain[m] = gChain[m-1] | (pChain[m-1] & gLvl[lv][SRC]);
          assign pChain[m] = pChain[m-1] & pLvl[lv][SRC];
        end else begin : gPass
          assign gChain[m] = gChain[m-1];
          assign pChain[m] = pChain[m-1];
        end
      end
      assign gLvl[lv+1][i] = gChain[VALENCY-1];
      assign pLvl[lv+1][i] = pChain[VALENCY-1];
    end
  end

  assign carry[0] = cin_i;
  for (genvar i = 0; i < WIDTH; i++) begin : gCarry
    assign carry[i+1] = gLvl[LEVELS][i] | (pLvl[LEVELS][i] & cin_i);
  end

  assign sum_o  = pLvl[0] ^ carry[WIDTH-1:0];
  assign cout_o = carry[WIDTH];

endmodule

// File: rtl/lf_multiprecision_sequencer.sv
// Multi-precision add/subtract sequencer: one WIDTH-bit prefix adder is
// reused over SLICES slices, least-significant first, with a registered
// carry linking the slices. Operands and results use valid/ready.
module lf_multiprecision_sequencer
  import lf_multiprecision_sequencer_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int SLICES  = 4,
  parameter int VALENCY = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH*SLICES-1:0]   op_a,
  input  logic [WIDTH*SLICES-1:0]   op_b,
  input  logic                      sub,
  input  logic                      cin,
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH*SLICES-1:0]   sum,
  output logic                      cout,
  output logic                      ovf,
  output logic                      busy
);

  localparam int TOTAL = WIDTH * SLICES;
  localparam int KW    = clog2(SLICES);
  localparam logic [KW-1:0] LAST_K = KW'(SLICES - 1);

  seqState_e        state_q, state_d;
  logic [TOTAL-1:0] opA_q, opA_d;
  logic [TOTAL-1:0] opB_q, opB_d;
  logic             carry_q, carry_d;
  logic [KW-1:0]    k_q, k_d;
  logic [TOTAL-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             outValid_q, outValid_d;

  logic [WIDTH-1:0] sliceA;
  logic [WIDTH-1:0] sliceB;
  logic [WIDTH-1:0] adderSum;
  logic             adderCout;

  // The shared adder only ever sees registered operands and the carry register.
  assign sliceA = opA_q[int'(k_q)*WIDTH +: WIDTH];
  assign sliceB = opB_q[int'(k_q)*WIDTH +: WIDTH];

  Ladner_fischer_adder #(
    .WIDTH   (WIDTH),
    .VALENCY (VALENCY)
  ) uAdder (
    .a_i    (sliceA),
    .b_i    (sliceB),
    .cin_i  (carry_q),
    .sum_o  (adderSum),
    .cout_o (adderCout)
  );

  // Next-state logic: capture, slice sequencing, result hold, flush override.
  always_comb begin
    state_d    = state_q;
    opA_d      = opA_q;
    opB_d      = opB_q;
    carry_d    = carry_q;
    k_d        = k_q;
    sum_d      = sum_q;
    cout_d     = cout_q;
    ovf_d      = ovf_q;
    outValid_d = 1'b0;

    if (flush) begin
      state_d = IDLE;
      k_d     = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            opA_d   = op_a;
            opB_d   = sub ? ~op_b : op_b;
            carry_d = sub ? 1'b1 : cin;
            k_d     = '0;
            state_d = RUN;
          end
        end
        RUN: begin
          sum_d[int'(k_q)*WIDTH +: WIDTH] = adderSum;
          carry_d = adderCout;
          if (k_q == LAST_K) begin
            cout_d  = adderCout;
            ovf_d   = (opA_q[TOTAL-1] == opB_q[TOTAL-1]) &&
                      (adderSum[WIDTH-1] != opA_q[TOTAL-1]);
            k_d     = '0;
            state_d = DONE;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
        DONE: begin
          if (outValid_q && out_ready) begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
      // The result registers land on DONE entry; valid is presented one cycle later.
      outValid_d = (state_q == DONE) && (state_d == DONE);
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      opA_q      <= '0;
      opB_q      <= '0;
      carry_q    <= 1'b0;
      k_q        <= '0;
      sum_q      <= '0;
      cout_q     <= 1'b0;
      ovf_q      <= 1'b0;
      outValid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      opA_q      <= opA_d;
      opB_q      <= opB_d;
      carry_q    <= carry_d;
      k_q        <= k_d;
      sum_q      <= sum_d;
      cout_q     <= cout_d;
      ovf_q      <= ovf_d;
      outValid_q <= outValid_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == RUN) || (state_q == DONE);
  assign out_valid = outValid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_lf_multiprecision_sequencer.sv
// Scoreboard bench for the multi-precision sequencer: every accepted request
// pushes its expected result from an arithmetic reference model, and a monitor
// pops and compares whenever a result is handed over.
module tb_lf_multiprecision_sequencer;

  localparam int WIDTH   = 16;
  localparam int SLICES  = 4;
  localparam int VALENCY = 2;
  localparam int TOTAL   = WIDTH * SLICES;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [TOTAL-1:0] op_a;
  logic [TOTAL-1:0] op_b;
  logic             sub;
  logic             cin;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [TOTAL-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             busy;

  typedef struct packed {
    logic [TOTAL-1:0] sum;
    logic             cout;
    logic             ovf;
  } expect_t;

  expect_t sbQ[$];
  int      total = 0;
  int      bad   = 0;
  bit      randReady = 0;

  lf_multiprecision_sequencer #(
    .WIDTH   (WIDTH),
    .SLICES  (SLICES),
    .VALENCY (VALENCY)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .sub       (sub),
    .cin       (cin),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain wide arithmetic; signed overflow from a sign-extended sum.
  function automatic expect_t refModel(input logic [TOTAL-1:0] a, input logic [TOTAL-1:0] b,
                                       input logic s, input logic c);
    expect_t          e;
    logic [TOTAL:0]   wide;
    logic [TOTAL+1:0] sWide;
    logic [TOTAL+1:0] aExt;
    logic [TOTAL+1:0] bExt;
    aExt = {{2{a[TOTAL-1]}}, a};
    bExt = {{2{b[TOTAL-1]}}, b};
    if (s) begin
      e.sum  = a - b;
      e.cout = (a >= b);
      sWide  = aExt - bExt;
    end else begin
      wide   = {1'b0, a} + {1'b0, b} + (TOTAL+1)'(c);
      e.sum  = wide[TOTAL-1:0];
      e.cout = wide[TOTAL];
      sWide  = aExt + bExt + (TOTAL+2)'(c);
    end
    e.ovf = (sWide[TOTAL] != sWide[TOTAL-1]);
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [TOTAL-1:0] act,
                             input logic [TOTAL-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Drive a request, wait (bounded) for acceptance, then record its expected result.
  task automatic applyStimulus(input logic [TOTAL-1:0] a, input logic [TOTAL-1:0] b,
                               input logic s, input logic c);
    bit accepted;
    accepted = 1'b0;
    op_a = a;
    op_b = b;
    sub = s;
    cin = c;
    in_valid = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (in_ready && !flush) begin
        accepted = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
      if (randReady) out_ready = ($urandom_range(0, 2) != 0);
    end
    if (accepted) begin
      sbQ.push_back(refModel(a, b, s, c));
      @(posedge clk);
      #1;
    end else begin
      total++;
      bad++;
      $display("[TB] FAIL accept_timeout: got in_ready=%0b, want 1", in_ready);
    end
    in_valid = 1'b0;
  endtask

  // Wait (bounded) until every expected result has been handed over.
  task automatic waitDrain(input int budget);
    for (int n = 0; n < budget; n++) begin
      if (sbQ.size() == 0) break;
      @(posedge clk);
      #1;
      if (randReady) out_ready = ($urandom_range(0, 2) != 0);
    end
    checkOutput("drain", 64'(sbQ.size()), 64'd0);
  endtask

  // Monitor: compare each handed-over result with the oldest expectation.
  initial begin
    expect_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (sbQ.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_result: got sum=%h, want no result", sum);
        end else begin
          e = sbQ.pop_front();
          checkOutput("sum", sum, e.sum);
          checkOutput("cout", 64'(cout), 64'(e.cout));
          checkOutput("ovf", 64'(ovf), 64'(e.ovf));
        end
      end
    end
  end

  // Directed scenarios followed by a randomized phase.
  initial begin
    logic [TOTAL-1:0] heldSum;
    logic [1:0]       heldFlags;
    int               lat;
    logic [TOTAL-1:0] ra;
    logic [TOTAL-1:0] rb;

    rst_n = 1'b0;
    in_valid = 1'b0;
    op_a = '0;
    op_b = '0;
    sub = 1'b0;
    cin = 1'b0;
    flush = 1'b0;
    out_ready = 1'b0;

    #12;
    checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_sum", sum, 64'd0);
    checkOutput("rst_cout", 64'(cout), 64'd0);
    checkOutput("rst_ovf", 64'(ovf), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // All-ones plus one wraps to zero with carry out; measure latency.
    out_ready = 1'b1;
    applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
    lat = 0;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = n;
        break;
      end
    end
    checkOutput("latency", 64'(lat), 64'd5);
    waitDrain(20);

    // Subtraction with and without borrow, signed overflow both ways, cross-slice carry.
    applyStimulus(64'd5, 64'd7, 1'b1, 1'b0);
    applyStimulus(64'd7, 64'd5, 1'b1, 1'b0);
    applyStimulus(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
    applyStimulus(64'h8000_0000_0000_0000, 64'd1, 1'b1, 1'b0);
    applyStimulus(64'h0000_0000_0000_FFFF, 64'd0, 1'b0, 1'b1);
    waitDrain(60);

    // Backpressure: result held while a second request waits at the input.
    out_ready = 1'b0;
    applyStimulus(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 1'b1);
    op_a = 64'hDEAD_BEEF_0000_FFFF;
    op_b = 64'h0000_0001_FFFF_0001;
    sub = 1'b1;
    cin = 1'b0;
    in_valid = 1'b1;
    for (int n = 0; n < 20; n++) begin
      if (out_valid) break;
      @(posedge clk);
      #1;
    end
    heldSum = sum;
    heldFlags = {cout, ovf};
    for (int n = 0; n < 10; n++) begin
      @(posedge clk);
      #1;
      checkOutput("bp_out_valid", 64'(out_valid), 64'd1);
      checkOutput("bp_in_ready", 64'(in_ready), 64'd0);
      checkOutput("bp_sum_stable", sum, heldSum);
      checkOutput("bp_flags_stable", 64'({cout, ovf}), 64'(heldFlags));
    end
    out_ready = 1'b1;
    applyStimulus(64'hDEAD_BEEF_0000_FFFF, 64'h0000_0001_FFFF_0001, 1'b1, 1'b0);
    waitDrain(20);

    // Asynchronous reset while slice 2 is being added.
    applyStimulus(64'hAAAA_5555_AAAA_5555, 64'h1111_2222_3333_4444, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("arst_in_ready", 64'(in_ready), 64'd1);
    checkOutput("arst_busy", 64'(busy), 64'd0);
    checkOutput("arst_sum", sum, 64'd0);
    void'(sbQ.pop_back());
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1, 1'b0);
    waitDrain(20);

    // Synchronous flush while slice 2 is being added.
    applyStimulus(64'hFFFF_0000_FFFF_0000, 64'h0001_0001_0001_0001, 1'b0, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    checkOutput("flush_in_ready", 64'(in_ready), 64'd1);
    checkOutput("flush_out_valid", 64'(out_valid), 64'd0);
    checkOutput("flush_busy", 64'(busy), 64'd0);
    void'(sbQ.pop_back());
    for (int n = 0; n < 8; n++) begin
      @(posedge clk);
      #1;
      checkOutput("flush_no_valid", 64'(out_valid), 64'd0);
    end

    // Flush together with a request in IDLE: the request is ignored.
    op_a = 64'd99;
    op_b = 64'd1;
    sub = 1'b0;
    cin = 1'b0;
    in_valid = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush = 1'b0;
    checkOutput("flush_idle_busy", 64'(busy), 64'd0);
    applyStimulus(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0);
    waitDrain(20);

    // Randomized phase with random result backpressure.
    randReady = 1'b1;
    for (int i = 0; i < 40; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      if (i % 5 == 0) ra = {TOTAL{1'b1}};
      if (i % 7 == 0) rb = {1'b1, {(TOTAL-1){1'b0}}};
      applyStimulus(ra, rb, 1'(($urandom % 2)), 1'(($urandom % 2)));
      for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
        @(posedge clk);
        #1;
        out_ready = ($urandom_range(0, 2) != 0);
      end
    end
    waitDrain(500);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
